// File: rtl/sdram_device_model_if.sv
// Command/data bus between an SDRAM controller (master) and sdram_device_model (slave).
interface sdram_device_model_if;
  logic        cke;
  logic        cs;
  logic        ras;
  logic        cas;
  logic        we;
  logic        dqm;
  logic [1:0]  ba;
  logic [12:0] a;
  logic [31:0] dqi;
  logic [31:0] dqo;
  logic        dqo_valid;
  logic        err;
  logic [2:0]  err_code;

  modport master (
    output cke, cs, ras, cas, we, dqm, ba, a, dqi,
    input  dqo, dqo_valid, err, err_code
  );

  modport slave (
    input  cke, cs, ras, cas, we, dqm, ba, a, dqi,
    output dqo, dqo_valid, err, err_code
  );
endinterface

// File: rtl/sdram_device_model.sv
// Cycle-accurate SDRAM device model: command decode, per-bank rows/timers, CL-delayed read bursts.
// Define SDRAM_MODEL_CHECK_EN to compile in the protocol checker driving err/err_code.
module sdram_device_model #(
  parameter int unsigned ROW_BITS     = 3,
  parameter logic [12:0] MODE_DEFAULT = 13'h0022,
  parameter int unsigned TRCD         = 3,
  parameter int unsigned TRP          = 3,
  parameter int unsigned TRFC         = 7,
  parameter int unsigned TREFI_MAX    = 1024
) (
  input logic                 clk,
  input logic                 rst,
  sdram_device_model_if.slave bus_io
);
  localparam int unsigned AddrW = 2 + ROW_BITS + 8;
  localparam int unsigned Depth = 1 << AddrW;
  localparam int unsigned TimW  = 8;

  typedef enum logic [2:0] {
    CmdNop, CmdActive, CmdRead, CmdWrite, CmdBst, CmdPre, CmdRef, CmdLmr
  } cmd_e;

  typedef enum logic [0:0] {StIdle, StBurst} st_e;

  logic [31:0] mem [Depth];

  st_e                            st_q, st_d;
  logic [3:0]                     open_q, open_d;
  logic [3:0][ROW_BITS-1:0]       row_q, row_d;
  logic [3:0][TimW-1:0]           btim_q, btim_d;
  logic [TimW-1:0]                gtim_q, gtim_d;
  logic [12:0]                    mode_q, mode_d;
  logic [1:0]                     bst_bank_q, bst_bank_d;
  logic [ROW_BITS-1:0]            bst_row_q, bst_row_d;
  logic [7:0]                     bst_col_q, bst_col_d;
  logic [3:0]                     bst_cnt_q, bst_cnt_d;
  logic [2:0]                     bst_mask_q, bst_mask_d;
  logic                           s1_valid_q, s1_valid_d;
  logic [31:0]                    s1_data_q, s1_data_d;
  logic [31:0]                    dqo_q, dqo_d;
  logic                           dqo_valid_q, dqo_valid_d;

  cmd_e             cmd;
  logic [2:0]       bl_mask;
  logic             cl3;
  logic             stop;
  logic             issue;
  logic             mem_we;
  logic [AddrW-1:0] issue_addr;
  logic [AddrW-1:0] wr_addr;
  logic [31:0]      rd_word;
  logic             unused_mode;

  always_comb begin
    cmd = CmdNop;
    if (!bus_io.cs) begin
      case ({bus_io.ras, bus_io.cas, bus_io.we})
        3'b011:  cmd = CmdActive;
        3'b101:  cmd = CmdRead;
        3'b100:  cmd = CmdWrite;
        3'b110:  cmd = CmdBst;
        3'b010:  cmd = CmdPre;
        3'b001:  cmd = CmdRef;
        3'b000:  cmd = CmdLmr;
        default: cmd = CmdNop;
      endcase
    end
  end

  always_comb begin
    case (mode_q[2:0])
      3'd1:    bl_mask = 3'd1;
      3'd2:    bl_mask = 3'd3;
      3'd3:    bl_mask = 3'd7;
      default: bl_mask = 3'd0;
    endcase
  end

  assign cl3         = (mode_q[6:4] == 3'd3);
  assign unused_mode = ^{mode_q[12:7], mode_q[3]};
  assign issue_addr  = {bst_bank_q, bst_row_q, bst_col_q};
  assign wr_addr     = {bus_io.ba, row_q[bus_io.ba], bus_io.a[9:2]};
  assign rd_word     = mem[issue_addr];

  always_comb begin
    st_d        = st_q;
    open_d      = open_q;
    row_d       = row_q;
    mode_d      = mode_q;
    bst_bank_d  = bst_bank_q;
    bst_row_d   = bst_row_q;
    bst_col_d   = bst_col_q;
    bst_cnt_d   = bst_cnt_q;
    bst_mask_d  = bst_mask_q;
    s1_valid_d  = 1'b0;
    s1_data_d   = s1_data_q;
    dqo_d       = dqo_q;
    dqo_valid_d = 1'b0;
    issue       = 1'b0;
    mem_we      = 1'b0;
    gtim_d      = (gtim_q == '0) ? '0 : gtim_q - 1'b1;
    for (int b = 0; b < 4; b++) begin
      btim_d[b] = (btim_q[b] == '0) ? '0 : btim_q[b] - 1'b1;
    end

    // A new READ lets the old burst issue this edge, so data stays back-to-back.
    stop = (cmd == CmdWrite) || (cmd == CmdBst) ||
           ((cmd == CmdPre) && (bus_io.a[10] || (bus_io.ba == bst_bank_q)));

    if (st_q == StBurst) begin
      if (stop) begin
        st_d = StIdle;
      end else begin
        issue     = 1'b1;
        bst_col_d = {bst_col_q[7:3],
                     (bst_col_q[2:0] & ~bst_mask_q) | ((bst_col_q[2:0] + 3'd1) & bst_mask_q)};
        bst_cnt_d = bst_cnt_q - 4'd1;
        if (bst_cnt_q == 4'd1) st_d = StIdle;
      end
    end

    if (s1_valid_q) begin
      dqo_valid_d = 1'b1;
      dqo_d       = s1_data_q;
    end else if (issue && !cl3) begin
      dqo_valid_d = 1'b1;
      dqo_d       = rd_word;
    end
    if (issue && cl3) begin
      s1_valid_d = 1'b1;
      s1_data_d  = rd_word;
    end

    case (cmd)
      CmdActive: begin
        open_d[bus_io.ba] = 1'b1;
        row_d[bus_io.ba]  = bus_io.a[ROW_BITS-1:0];
        btim_d[bus_io.ba] = TimW'(TRCD);
      end
      CmdRead: begin
        st_d       = StBurst;
        bst_bank_d = bus_io.ba;
        bst_row_d  = row_q[bus_io.ba];
        bst_col_d  = bus_io.a[9:2];
        bst_mask_d = bl_mask;
        bst_cnt_d  = {1'b0, bl_mask} + 4'd1;
      end
      CmdWrite: mem_we = !bus_io.dqm;
      CmdPre: begin
        for (int b = 0; b < 4; b++) begin
          if (bus_io.a[10] || (bus_io.ba == 2'(b))) begin
            open_d[b] = 1'b0;
            btim_d[b] = TimW'(TRP);
          end
        end
      end
      CmdRef:  gtim_d = TimW'(TRFC);
      CmdLmr:  mode_d = bus_io.a;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      open_q      <= '0;
      row_q       <= '0;
      btim_q      <= '0;
      gtim_q      <= '0;
      mode_q      <= MODE_DEFAULT;
      bst_bank_q  <= '0;
      bst_row_q   <= '0;
      bst_col_q   <= '0;
      bst_cnt_q   <= '0;
      bst_mask_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      dqo_q       <= '0;
      dqo_valid_q <= 1'b0;
    end else if (bus_io.cke) begin
      st_q        <= st_d;
      open_q      <= open_d;
      row_q       <= row_d;
      btim_q      <= btim_d;
      gtim_q      <= gtim_d;
      mode_q      <= mode_d;
      bst_bank_q  <= bst_bank_d;
      bst_row_q   <= bst_row_d;
      bst_col_q   <= bst_col_d;
      bst_cnt_q   <= bst_cnt_d;
      bst_mask_q  <= bst_mask_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      dqo_q       <= dqo_d;
      dqo_valid_q <= dqo_valid_d;
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && bus_io.cke && mem_we) mem[wr_addr] <= bus_io.dqi;
  end

  assign bus_io.dqo       = dqo_q;
  assign bus_io.dqo_valid = dqo_valid_q;

`ifdef SDRAM_MODEL_CHECK_EN
  logic [31:0] refi_q, refi_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  viol;

  // Timers are judged after this cycle's decrement, so a command exactly TRCD/TRP/TRFC
  // cycles after its predecessor is legal.
  always_comb begin
    viol   = 3'd0;
    refi_d = (cmd == CmdRef) ? '0 : ((refi_q == '1) ? refi_q : refi_q + 32'd1);
    if (((cmd == CmdRead) || (cmd == CmdWrite)) && !open_q[bus_io.ba]) begin
      viol = 3'd1;
    end else if ((cmd == CmdActive) && open_q[bus_io.ba]) begin
      viol = 3'd2;
    end else if ((cmd inside {CmdActive, CmdRead, CmdWrite}) && (btim_q[bus_io.ba] > 1)) begin
      viol = 3'd3;
    end else if ((cmd != CmdNop) && (gtim_q > 1)) begin
      viol = 3'd4;
    end else if ((cmd == CmdRef) && (|open_q)) begin
      viol = 3'd5;
    end else if (refi_q > TREFI_MAX) begin
      viol = 3'd6;
    end else if ((cmd == CmdLmr) && !(bus_io.a[6:4] inside {3'd2, 3'd3})) begin
      viol = 3'd7;
    end
    err_d  = err_q | (viol != 3'd0);
    code_d = (!err_q && (viol != 3'd0)) ? viol : code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refi_q <= '0;
      err_q  <= 1'b0;
      code_q <= '0;
    end else if (bus_io.cke) begin
      refi_q <= refi_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign bus_io.err      = err_q;
  assign bus_io.err_code = code_q;
`else
  assign bus_io.err      = 1'b0;
  assign bus_io.err_code = 3'd0;
`endif
endmodule

// File: doc/sdram_device_model.md
# sdram_device_model

- Cycle-accurate, synthesizable SDRAM device model that answers the command stream produced by `sdram_controller`.
- Decodes ACTIVE, READ, WRITE, PRECHARGE, REFRESH, LOAD MODE and BURST TERMINATE, and tracks open rows per bank.
- Returns read data after the programmed CAS latency, in bursts.
- Sits under the user project in place of the external SDRAM pins so that firmware and controller changes can be simulated and FPGA-prototyped.

## Interface
- `ROW_BITS`, 3: low row-address bits stored. Depth = 4 × 2^ROW_BITS × 256 words; rows alias modulo 2^ROW_BITS.
- `MODE_DEFAULT`, 13'h0022: mode register value after reset (CL=2, BL=4, sequential).
- `TRCD`, 3: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- `TRP`, 3: minimum cycles from PRECHARGE to ACTIVE on the same bank.
- `TRFC`, 7: minimum cycles from REFRESH to any non-NOP command.
- `TREFI_MAX`, 1024: maximum cycles between REFRESH commands.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `cke`, in, 1: clock enable. When low, inputs are ignored and all state is frozen.
- `cs`, in, 1: command chip select, active-low.
- `ras`, in, 1: command RAS strobe, active-low.
- `cas`, in, 1: command CAS strobe, active-low.
- `we`, in, 1: command write enable, active-low.
- `dqm`, in, 1: write mask, sampled with WRITE.
- `ba`, in, 2: bank address.
- `a`, in, 13: row for ACTIVE; column in `a[9:2]` for READ/WRITE; `a[10]` = all-banks for PRECHARGE.
- `dqi`, in, 32: write data; connects to controller `sdram_dqo`.
- `dqo`, out, 32: read data; connects to controller `sdram_dqi`. Holds its last value when not valid.
- `dqo_valid`, out, 1: `dqo` carries a burst word this cycle.
- `err`, out, 1: sticky protocol-error flag.
- `err_code`, out, 3: code of the first error detected.

## Operation
- Command = {`cs`,`ras`,`cas`,`we`}, sampled on the rising edge when `cke`=1:
  - 1xxx and 0111: NOP.
  - 0011: ACTIVE.
  - 0101: READ.
  - 0100: WRITE.
  - 0110: BURST TERMINATE.
  - 0010: PRECHARGE.
  - 0001: REFRESH.
  - 0000: LOAD MODE.
- Per-bank state: `open` flag, `row` register, and a down-counter for the bank timer.
- ACTIVE:
  - Sets `open` and latches `row = a`.
  - Loads the bank timer with TRCD.
- PRECHARGE:
  - Clears `open` for bank `ba`, or for all banks when `a[10]`=1.
  - Loads the affected bank timers with TRP.
- REFRESH:
  - Loads the global timer with TRFC.
  - Resets the refresh-interval counter.
- LOAD MODE: `mode <= a`.
  - CL = `mode[6:4]`; only 2 and 3 are legal.
  - BL = 1, 2, 4 or 8, from `mode[2:0]`.
- Memory index = {`ba`, `row[ROW_BITS-1:0]`, column}.
- WRITE:
  - Stores `dqi` at the sampled column, unless `dqm`=1.
  - Writes are always single-word.
- READ:
  - Starts a burst of BL words.
  - Column increments by 1 and wraps within the BL-aligned block (sequential mode).
- Burst termination:
  - A new READ truncates the running burst; the new burst starts CL after its own command.
  - WRITE, BURST TERMINATE, or PRECHARGE of the bursting bank stops the burst immediately. Words still in the CL pipeline are delivered.
- Memory is not cleared on reset.

## Timing
- Reset values: `dqo`=0, `dqo_valid`=0, `err`=0, `err_code`=0, `mode`=MODE_DEFAULT, all banks closed, all timers 0, no burst active.
- Reset mid-burst aborts the burst; `dqo_valid` is 0 on the next cycle.
- Read latency:
  - READ sampled at edge E0 → first word has `dqo_valid`=1 during the cycle following edge E(CL-1).
  - The word is therefore stable at edge E(CL).
  - Following burst words arrive on consecutive cycles.
- WRITE data is sampled at the same edge as the command (zero latency).
- A READ on the cycle after a WRITE to the same address returns the new data.
- A READ and a PRECHARGE of the same bank in consecutive cycles: burst words already issued complete.
- Bank and global timers count down by 1 per enabled cycle and saturate at 0.

## Configuration
- `SDRAM_MODEL_CHECK_EN` defined: protocol checker compiled in. It sets `err` and latches the first `err_code`:
  - 1: READ/WRITE to a closed bank.
  - 2: ACTIVE to an open bank.
  - 3: command issued while its bank timer is nonzero.
  - 4: command issued while the TRFC timer is nonzero.
  - 5: REFRESH with any bank open.
  - 6: refresh-interval counter exceeds TREFI_MAX.
  - 7: illegal CL in LOAD MODE (mode is still updated).
- `SDRAM_MODEL_CHECK_EN` undefined: checker logic is absent; `err` and `err_code` are tied to 0. Functional behaviour is otherwise identical.

## Test plan
- ACTIVE bank 1 row 5; WRITE col 8 data 32'hA5A5_0001 three cycles later; READ col 8 three cycles after that → `dqo_valid` at CL=2; words 32'hA5A5_0001, then cols 9, 10, 11; `err`=0.
- LOAD MODE a=13'h0030 (CL=3, BL=1); READ → a single word, one cycle later than with CL=2.
- WRITE with `dqm`=1 over an existing 32'h1234_5678 → a read returns 32'h1234_5678.
- READ col 6 (BL=4) → order 6, 7, 4, 5. A new READ col 0 two cycles later truncates the first burst; col 0 data follows at CL.
- With the check macro: READ one cycle after ACTIVE → `err`=1, `err_code`=3. No REFRESH for 1025 cycles → `err_code` stays 3 (first error held).
- `cke` low for 4 cycles during a burst → `dqo` is held and the remaining words resume afterwards; `rst` mid-burst → `dqo_valid`=0 the next cycle.
